// File: rtl/spi_eeprom_reader_pkg.sv
// Shared opcodes, FSM encodings and the latched request record for the
// 25AA512 SPI EEPROM reader.
package spi_eeprom_reader_pkg;

   localparam int ADDR_W = 16;

   localparam logic [7:0] CMD_READ = 8'h03;
   localparam logic [7:0] CMD_RDSR = 8'h05;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CSS  = 3'd1;
   localparam logic [2:0] ST_CMD  = 3'd2;
   localparam logic [2:0] ST_ADDR = 3'd3;
   localparam logic [2:0] ST_DATA = 3'd4;
   localparam logic [2:0] ST_CSH  = 3'd5;
   localparam logic [2:0] ST_GAP  = 3'd6;

   typedef struct packed {
      logic              rdsr;
      logic [ADDR_W-1:0] addr;
   } req_t;

   // Status reads always return one byte; a READ length of zero means 256.
   function automatic logic [8:0] len_to_bytes(input logic rdsr, input logic [7:0] len);
      if (rdsr)
         return 9'd1;
      else if (len == 8'd0)
         return 9'd256;
      else
         return {1'b0, len};
   endfunction

endpackage

// File: rtl/spi_eeprom_reader_bit_engine.sv
// SPI mode-0 bit engine: half-period divider, SCK generation and a shared
// MOSI/MISO shift register that moves one byte at a time for the sequencer.
module spi_bit_engine
   import spi_eeprom_reader_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       active,
   input  logic       shifting,
   input  logic       load,
   input  logic [7:0] tx_byte,
   input  logic       so,
   output logic       tick,
   output logic       sck,
   output logic       si,
   output logic       byte_done,
   output logic       byte_end,
   output logic [7:0] rx_byte
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [7:0]       sreg;
   logic [2:0]       bit_cnt;

   assign tick      = active && (div_cnt == DIV_LAST);
   assign rx_byte   = {sreg[6:0], so};
   assign byte_done = tick && shifting && !sck && (bit_cnt == 3'd7);
   assign byte_end  = tick && shifting && sck && (bit_cnt == 3'd0);

   // Rising ticks shift in SO; falling ticks present the next SI bit, or the
   // next byte's MSB once all eight bits of the current byte have gone out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         sck     <= 1'b0;
         si      <= 1'b0;
         sreg    <= 8'h00;
         bit_cnt <= 3'd0;
      end else begin
         if (!active || tick)
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + 1'b1;

         if (load) begin
            sreg    <= tx_byte;
            si      <= tx_byte[7];
            bit_cnt <= 3'd0;
            sck     <= 1'b0;
         end else if (!active) begin
            sck <= 1'b0;
            si  <= 1'b0;
         end else if (tick && shifting) begin
            sck <= ~sck;
            if (!sck) begin
               sreg    <= rx_byte;
               bit_cnt <= bit_cnt + 3'd1;
            end else if (bit_cnt == 3'd0) begin
               sreg <= tx_byte;
               si   <= tx_byte[7];
            end else begin
               si <= sreg[7];
            end
         end
      end
   end

endmodule

// File: rtl/spi_eeprom_reader.sv
// Transaction sequencer for the 25AA512: turns one {cmd, addr, len} request
// into a READ or RDSR frame and returns each received byte as a pulse.
module spi_eeprom_reader
   import spi_eeprom_reader_pkg::*;
#(
   parameter int CLK_DIV  = 1,
   parameter int GAP_HALF = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_cmd,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_len,
   output logic        data_valid,
   output logic [7:0]  data_byte,
   output logic        done,
   output logic        busy,
   output logic        flash_si,
   input  logic        flash_so,
   output logic        flash_sck,
   output logic        flash_cs_n,
   output logic        flash_wp_n,
   output logic        flash_hold_n
);

   logic [2:0] state;
   req_t       req_q;
   logic       addr_lo;
   logic [8:0] byte_cnt;
   logic       accept;
   logic       active;
   logic       shifting;
   logic       tick;
   logic       byte_done;
   logic       byte_end;
   logic [7:0] tx_byte;
   logic [7:0] rx_byte;

   assign accept       = req_valid && req_ready;
   assign active       = (state != ST_IDLE);
   assign shifting     = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
   assign flash_wp_n   = 1'b1;
   assign flash_hold_n = 1'b1;

   // Byte the engine loads at the next byte boundary (or at accept).
   always_comb begin
      tx_byte = 8'h00;
      case (state)
         ST_IDLE: tx_byte = req_cmd ? CMD_RDSR : CMD_READ;
         ST_CMD:  tx_byte = req_q.rdsr ? 8'h00 : req_q.addr[15:8];
         ST_ADDR: tx_byte = addr_lo ? 8'h00 : req_q.addr[7:0];
         default: tx_byte = 8'h00;
      endcase
   end

   spi_bit_engine #(
      .CLK_DIV (CLK_DIV)
   ) u_engine (
      .clk       (clk),
      .reset     (reset),
      .active    (active),
      .shifting  (shifting),
      .load      (accept),
      .tx_byte   (tx_byte),
      .so        (flash_so),
      .tick      (tick),
      .sck       (flash_sck),
      .si        (flash_si),
      .byte_done (byte_done),
      .byte_end  (byte_end),
      .rx_byte   (rx_byte)
   );

   // byte_cnt holds the remaining data bytes, then is reused to time the gap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         req_q      <= '0;
         addr_lo    <= 1'b0;
         byte_cnt   <= 9'd0;
         req_ready  <= 1'b0;
         busy       <= 1'b0;
         flash_cs_n <= 1'b1;
         done       <= 1'b0;
         data_valid <= 1'b0;
         data_byte  <= 8'h00;
      end else begin
         done       <= 1'b0;
         data_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  req_q.rdsr <= req_cmd;
                  req_q.addr <= req_addr;
                  byte_cnt   <= len_to_bytes(req_cmd, req_len);
                  addr_lo    <= 1'b0;
                  flash_cs_n <= 1'b0;
                  busy       <= 1'b1;
                  req_ready  <= 1'b0;
                  state      <= ST_CSS;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            ST_CSS: begin
               if (tick)
                  state <= ST_CMD;
            end
            ST_CMD: begin
               if (byte_end)
                  state <= req_q.rdsr ? ST_DATA : ST_ADDR;
            end
            ST_ADDR: begin
               if (byte_end) begin
                  if (addr_lo)
                     state <= ST_DATA;
                  else
                     addr_lo <= 1'b1;
               end
            end
            ST_DATA: begin
               if (byte_done) begin
                  data_byte  <= rx_byte;
                  data_valid <= 1'b1;
               end
               if (byte_end) begin
                  if (byte_cnt == 9'd1)
                     state <= ST_CSH;
                  else
                     byte_cnt <= byte_cnt - 9'd1;
               end
            end
            ST_CSH: begin
               if (tick) begin
                  flash_cs_n <= 1'b1;
                  done       <= 1'b1;
                  byte_cnt   <= 9'(GAP_HALF);
                  state      <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (tick) begin
                  if (byte_cnt <= 9'd1) begin
                     busy      <= 1'b0;
                     req_ready <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     byte_cnt <= byte_cnt - 9'd1;
                  end
               end
            end
            default: begin
               state      <= ST_IDLE;
               flash_cs_n <= 1'b1;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_eeprom_reader.sv
// Bench for spi_eeprom_reader with a behavioural 25AA512 model: table-driven
// transactions plus hand-written reset-abort and back-to-back request cases.
module tb_spi_eeprom_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_cmd;
   logic [15:0] req_addr;
   logic [7:0]  req_len;
   logic        data_valid;
   logic [7:0]  data_byte;
   logic        done;
   logic        busy;
   logic        flash_si;
   logic        flash_so = 1'b0;
   logic        flash_sck;
   logic        flash_cs_n;
   logic        flash_wp_n;
   logic        flash_hold_n;

   int errors = 0;
   int checks = 0;

   spi_eeprom_reader #(
      .CLK_DIV  (1),
      .GAP_HALF (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_cmd      (req_cmd),
      .req_addr     (req_addr),
      .req_len      (req_len),
      .data_valid   (data_valid),
      .data_byte    (data_byte),
      .done         (done),
      .busy         (busy),
      .flash_si     (flash_si),
      .flash_so     (flash_so),
      .flash_sck    (flash_sck),
      .flash_cs_n   (flash_cs_n),
      .flash_wp_n   (flash_wp_n),
      .flash_hold_n (flash_hold_n)
   );

   always #5 clk = ~clk;

   // EEPROM model: samples SI on SCK rise, drives SO after SCK fall.
   logic [7:0]  mem [0:65535];
   logic        wel = 1'b0;
   int          rise_cnt = 0;
   int          data_start = 0;
   logic        data_on = 1'b0;
   logic [7:0]  in_sr = 8'h00;
   logic [7:0]  opcode = 8'h00;
   logic [15:0] maddr = 16'h0000;
   logic [7:0]  out_sr = 8'h00;
   int          sck_rises = 0;
   int          idle_rises = 0;

   always @(negedge flash_cs_n or posedge flash_sck) begin
      if (!flash_sck) begin
         rise_cnt = 0;
         data_on  = 1'b0;
         opcode   = 8'h00;
      end else if (flash_cs_n) begin
         idle_rises++;
      end else begin
         sck_rises++;
         in_sr = {in_sr[6:0], flash_si};
         rise_cnt++;
         if (rise_cnt == 8) begin
            opcode = in_sr;
            if (opcode == 8'h05) begin
               data_on    = 1'b1;
               data_start = 8;
            end
         end
         if (opcode == 8'h03 && rise_cnt == 16) maddr[15:8] = in_sr;
         if (opcode == 8'h03 && rise_cnt == 24) begin
            maddr[7:0] = in_sr;
            data_on    = 1'b1;
            data_start = 24;
         end
      end
   end

   always @(negedge flash_sck) begin
      int k;
      if (!flash_cs_n && data_on) begin
         k = rise_cnt - data_start;
         if (k % 8 == 0)
            out_sr = (opcode == 8'h05) ? {6'b0, wel, 1'b0} : mem[16'(maddr + 16'(k / 8))];
         flash_so = out_sr[7];
         out_sr   = {out_sr[6:0], 1'b0};
      end
   end

   // Output monitor, sampled on the falling clock edge.
   logic [7:0] rx_q[$];
   int done_total = 0;
   int busy_total = 0;
   int overlap_total = 0;

   always @(negedge clk) begin
      if (data_valid) rx_q.push_back(data_byte);
      if (done) done_total++;
      if (busy) busy_total++;
      if (busy && req_ready) overlap_total++;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
      end
   endtask

   task automatic waitReady(output logic ok);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = req_ready;
   endtask

   task automatic waitIdle(output logic ok);
      int n;
      n = 0;
      while (busy && n < 20000) begin
         @(negedge clk);
         n++;
      end
      ok = !busy;
   endtask

   task automatic applyStimulus(input logic cmd, input logic [15:0] addr, input logic [7:0] len,
                                output int rx0, output int n_rx, output int busy_cyc,
                                output int rises, output int dones,
                                output logic accepted, output logic finished);
      int busy0, done0, rise0;
      @(negedge clk);
      rx0   = rx_q.size();
      busy0 = busy_total;
      done0 = done_total;
      rise0 = sck_rises;
      req_cmd   = cmd;
      req_addr  = addr;
      req_len   = len;
      req_valid = 1'b1;
      waitReady(accepted);
      @(negedge clk);
      req_valid = 1'b0;
      waitIdle(finished);
      n_rx     = rx_q.size() - rx0;
      busy_cyc = busy_total - busy0;
      rises    = sck_rises - rise0;
      dones    = done_total - done0;
   endtask

   typedef struct {
      logic        cmd;
      logic [15:0] addr;
      logic [7:0]  len;
      logic        wel;
      int          n_bytes;
      logic [7:0]  first_byte;
      logic [7:0]  last_byte;
      int          busy_cyc;
      int          rises;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int   rx0, n_rx, busy_cyc, rises, dones, base, mism, idle;
      logic acc, fin;
      logic [7:0] exp_b;

      for (int a = 0; a < 65536; a++) mem[a] = 8'(a) + 8'h11;
      mem[16'h0000] = 8'hA5;
      mem[16'h0001] = 8'h3C;
      mem[16'h0002] = 8'h7E;
      mem[16'h0003] = 8'h01;
      mem[16'hFFFE] = 8'hDE;
      mem[16'hFFFF] = 8'hAD;

      //              cmd   addr      len    wel   n    first  last   busy  rises
      vecs[0] = '{1'b0, 16'h0000, 8'd4, 1'b0,   4, 8'hA5, 8'h01,  116,   56};
      vecs[1] = '{1'b1, 16'h0000, 8'd0, 1'b1,   1, 8'h02, 8'h02,   36,   16};
      vecs[2] = '{1'b0, 16'hFFFE, 8'd4, 1'b0,   4, 8'hDE, 8'h3C,  116,   56};
      vecs[3] = '{1'b0, 16'h0010, 8'd0, 1'b0, 256, 8'h21, 8'h20, 4148, 2072};
      vecs[4] = '{1'b0, 16'h1234, 8'd1, 1'b0,   1, 8'h45, 8'h45,   68,   32};
      vecs[5] = '{1'b0, 16'h00FF, 8'd2, 1'b0,   2, 8'h10, 8'h11,   84,   40};
      vecs[6] = '{1'b1, 16'h0000, 8'd9, 1'b0,   1, 8'h00, 8'h00,   36,   16};

      reset     = 1'b1;
      req_valid = 1'b0;
      req_cmd   = 1'b0;
      req_addr  = 16'h0000;
      req_len   = 8'd0;
      repeat (3) @(negedge clk);
      checkOutput("reset cs_n",      int'(flash_cs_n),   1);
      checkOutput("reset sck",       int'(flash_sck),    0);
      checkOutput("reset si",        int'(flash_si),     0);
      checkOutput("reset wp_n",      int'(flash_wp_n),   1);
      checkOutput("reset hold_n",    int'(flash_hold_n), 1);
      checkOutput("reset req_ready", int'(req_ready),    0);
      checkOutput("reset busy",      int'(busy),         0);
      checkOutput("reset data_valid",int'(data_valid),   0);
      checkOutput("reset done",      int'(done),         0);
      checkOutput("reset data_byte", int'(data_byte),    0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("ready after reset", int'(req_ready), 1);

      for (int i = 0; i < 7; i++) begin
         wel = vecs[i].wel;
         applyStimulus(vecs[i].cmd, vecs[i].addr, vecs[i].len, rx0, n_rx, busy_cyc, rises, dones, acc, fin);
         checkOutput($sformatf("v%0d accepted", i), int'(acc), 1);
         checkOutput($sformatf("v%0d finished", i), int'(fin), 1);
         checkOutput($sformatf("v%0d bytes", i), n_rx, vecs[i].n_bytes);
         if (n_rx > 0) begin
            checkOutput($sformatf("v%0d first", i), int'(rx_q[rx0]), int'(vecs[i].first_byte));
            checkOutput($sformatf("v%0d last", i), int'(rx_q[rx0 + n_rx - 1]), int'(vecs[i].last_byte));
         end
         mism = 0;
         for (int k = 0; k < n_rx; k++) begin
            exp_b = vecs[i].cmd ? {6'b0, vecs[i].wel, 1'b0} : mem[16'(vecs[i].addr + 16'(k))];
            if (rx_q[rx0 + k] != exp_b) mism++;
         end
         checkOutput($sformatf("v%0d stream mismatches", i), mism, 0);
         checkOutput($sformatf("v%0d busy cycles", i), busy_cyc, vecs[i].busy_cyc);
         checkOutput($sformatf("v%0d sck rises", i), rises, vecs[i].rises);
         checkOutput($sformatf("v%0d done pulses", i), dones, 1);
      end
      wel = 1'b0;

      // Abort a READ in the middle of its address phase.
      @(negedge clk);
      base = done_total;
      rx0  = rx_q.size();
      rises = sck_rises;
      req_cmd = 1'b0; req_addr = 16'h0000; req_len = 8'd4; req_valid = 1'b1;
      waitReady(acc);
      checkOutput("abort accepted", int'(acc), 1);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (20) @(negedge clk);
      rises = sck_rises - rises;
      checkOutput("abort in addr phase", int'(rises > 8 && rises < 24), 1);
      reset = 1'b1;
      #1;
      checkOutput("abort cs_n", int'(flash_cs_n), 1);
      checkOutput("abort sck", int'(flash_sck), 0);
      checkOutput("abort busy", int'(busy), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort no done", done_total - base, 0);
      checkOutput("abort no data", rx_q.size() - rx0, 0);
      checkOutput("abort ready", int'(req_ready), 1);
      applyStimulus(1'b0, 16'h0003, 8'd1, rx0, n_rx, busy_cyc, rises, dones, acc, fin);
      checkOutput("post-abort bytes", n_rx, 1);
      if (n_rx > 0) checkOutput("post-abort byte", int'(rx_q[rx0]), 'h01);
      checkOutput("post-abort done", dones, 1);

      // Second request held while the first is still busy.
      @(negedge clk);
      base = done_total;
      rx0  = rx_q.size();
      mism = overlap_total;
      req_cmd = 1'b0; req_addr = 16'h0000; req_len = 8'd1; req_valid = 1'b1;
      waitReady(acc);
      @(negedge clk);
      req_addr = 16'h0002;
      checkOutput("b2b first busy", int'(busy), 1);
      waitIdle(fin);
      checkOutput("b2b ready after gap", int'(req_ready), 1);
      idle = 0;
      while (!busy && idle < 50) begin
         @(negedge clk);
         idle++;
      end
      req_valid = 1'b0;
      checkOutput("b2b idle cycles before accept", idle, 1);
      waitIdle(fin);
      checkOutput("b2b finished", int'(fin), 1);
      checkOutput("b2b ready while busy", overlap_total - mism, 0);
      checkOutput("b2b bytes", rx_q.size() - rx0, 2);
      if (rx_q.size() - rx0 == 2) begin
         checkOutput("b2b byte0", int'(rx_q[rx0]), 'hA5);
         checkOutput("b2b byte1", int'(rx_q[rx0 + 1]), 'h7E);
      end
      checkOutput("b2b done pulses", done_total - base, 2);
      checkOutput("sck rises with cs_n high", idle_rises, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
